// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_EXECB, S_LUI, S_AUIPC, S_ALUWB,
    S_JAL, S_JALR, S_JALWB, S_FAULT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States that hold a memory request open and are watched for timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port handshake between the control unit and memory.
// Handshake: mem_req stays high (with adr_src/mem_we stable) until the
// cycle in which memory returns mem_ready = 1; that cycle completes the
// transfer. mem_we is meaningful only while mem_req is high.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/mem_watchdog.sv
// Counts consecutive stalled cycles of a memory request and flags timeout.
module mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,      // a memory request is outstanding this cycle
  input  logic clr,     // memory completed the request this cycle
  output logic timeout
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Stall counter: restarts on completion or whenever no request is open.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr) cnt_d = '0;
    else            cnt_d = cnt_q + CW'(1);
  end

  // Timeout fires during the MEM_TIMEOUT-th consecutive stalled cycle.
  assign timeout = en && !clr && (cnt_q == CW'(MEM_TIMEOUT - 1));

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath with a shared memory port,
// memory watchdog and retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  multicycle_ctrl_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ctrl,
  output logic [1:0]       result_src,
  output logic             fault,
  output logic [CNT_W-1:0] instret,
  output state_t           state_dbg
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_req_s, mem_we_s, adr_src_s;
  logic             retire, wd_en, wd_timeout;

  // funct3 steers the ALU outside this block; nothing here depends on it.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign wd_en = is_mem_state(state_q);

  mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (reset),
    .en      (wd_en),
    .clr     (mem.mem_ready),
    .timeout (wd_timeout)
  );

  // Next state and per-state datapath controls; idle values first.
  always_comb begin
    state_d    = state_q;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    adr_src_s  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALUOUT;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem.mem_ready;
        pc_write   = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
        else if (wd_timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_EXECB;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
        else if (wd_timeout) state_d = S_FAULT;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        adr_src_s = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wd_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_ctrl  = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECB: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_ctrl   = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = branch_taken;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target computed in DECODE; ALU forms oldPC + 4.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_JALWB;
      end
      S_JALR: begin
        // PC is written before rd, so rd == rs1 still sees the old rs1.
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_d    = S_JALWB;
      end
      S_JALWB: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Retired-instruction count; no retire can occur while in FAULT.
  always_comb begin
    instret_d = instret_q + CNT_W'(retire);
  end

  // State and counter registers; reset drops any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign mem.mem_req = mem_req_s;
  assign mem.mem_we  = mem_we_s;
  assign mem.adr_src = adr_src_s;
  assign fault       = (state_q == S_FAULT);
  assign instret     = instret_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for the multicycle control FSM.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  // ---- clock / reset / DUT ----
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken;
  logic        ir_write, pc_write, reg_write, fault;
  logic [1:0]  alu_src_a, alu_src_b, alu_ctrl, result_src;
  logic [31:0] instret;
  state_t      state_dbg;
  logic [15:0] outs;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .mem          (mif),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .result_src   (result_src),
    .fault        (fault),
    .instret      (instret),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  assign outs = {mif.mem_req, mif.mem_we, mif.adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alu_ctrl, result_src, fault};

  // ---- checking ----
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] ex(input logic mreq, input logic we, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] ac, input logic [1:0] rs,
                                     input logic flt);
    return {mreq, we, adr, irw, pcw, rw, sa, sb, ac, rs, flt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_st(input string tag, input state_t es, input logic [15:0] eo);
    chk({tag, ".state"}, 64'(state_dbg), 64'(es));
    chk({tag, ".outs"}, 64'(outs), 64'(eo));
  endtask

  // ---- driver ----
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] fetch_go, fetch_wait, dec, aluwb, memadr, memrd, memwr, flt_o;

  initial begin
    fetch_go   = ex(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    fetch_wait = ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    dec        = ex(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    aluwb      = ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    memadr     = ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
    memrd      = ex(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    memwr      = ex(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    flt_o      = 16'h0001;

    opcode = OP_R; funct3 = 3'b000; branch_taken = 1'b0; mif.mem_ready = 1'b0;
    reset = 1'b1;
    #12;
    chk_st("reset", S_FETCH, fetch_wait);
    chk("reset.instret", 64'(instret), 64'd0);

    // R-type: 4 cycles
    reset = 1'b0; mif.mem_ready = 1'b1; #1;
    chk_st("r.fetch", S_FETCH, fetch_go);
    step(); chk_st("r.decode", S_DECODE, dec);
    step(); chk_st("r.exec", S_EXECR, ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
    step(); chk_st("r.wb", S_ALUWB, aluwb);
    chk("r.instret_pre", 64'(instret), 64'd0);
    step(); chk_st("r.done", S_FETCH, fetch_go);
    chk("r.instret", 64'(instret), 64'd1);

    // Load with three stalled MEMREAD cycles: 8 cycles total
    opcode = OP_LOAD;
    step(); chk_st("ld.decode", S_DECODE, dec);
    step(); chk_st("ld.memadr", S_MEMADR, memadr);
    step(); mif.mem_ready = 1'b0; #1;
    chk_st("ld.wait0", S_MEMREAD, memrd);
    step(); chk_st("ld.wait1", S_MEMREAD, memrd);
    step(); chk_st("ld.wait2", S_MEMREAD, memrd);
    step(); mif.mem_ready = 1'b1; #1;
    chk_st("ld.ready", S_MEMREAD, memrd);
    step(); chk_st("ld.wb", S_MEMWB, ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0));
    step(); chk_st("ld.done", S_FETCH, fetch_go);
    chk("ld.instret", 64'(instret), 64'd2);

    // Branch taken then not taken: 3 cycles each
    opcode = OP_BRANCH; branch_taken = 1'b1;
    step(); chk_st("bt.decode", S_DECODE, dec);
    step(); chk_st("bt.exec", S_EXECB, ex(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0));
    step(); chk_st("bt.done", S_FETCH, fetch_go);
    chk("bt.instret", 64'(instret), 64'd3);
    branch_taken = 1'b0;
    step(); chk_st("bn.decode", S_DECODE, dec);
    step(); chk_st("bn.exec", S_EXECB, ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0));
    step(); chk_st("bn.done", S_FETCH, fetch_go);
    chk("bn.instret", 64'(instret), 64'd4);

    // Store, no wait: 4 cycles
    opcode = OP_STORE;
    step(); chk_st("st.decode", S_DECODE, dec);
    step(); chk_st("st.memadr", S_MEMADR, memadr);
    step(); chk_st("st.write", S_MEMWRITE, memwr);
    step(); chk_st("st.done", S_FETCH, fetch_go);
    chk("st.instret", 64'(instret), 64'd5);

    // JAL: 4 cycles
    opcode = OP_JAL;
    step(); chk_st("jal.decode", S_DECODE, dec);
    step(); chk_st("jal.jal", S_JAL, ex(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
    step(); chk_st("jal.wb", S_JALWB, ex(0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b00, 2'b10, 0));
    step(); chk_st("jal.done", S_FETCH, fetch_go);
    chk("jal.instret", 64'(instret), 64'd6);

    // Store stalled, then async reset mid-request drops the write strobe
    opcode = OP_STORE;
    step(); chk_st("str.decode", S_DECODE, dec);
    step(); chk_st("str.memadr", S_MEMADR, memadr);
    step(); mif.mem_ready = 1'b0; #1;
    chk_st("str.wait0", S_MEMWRITE, memwr);
    step(); chk_st("str.wait1", S_MEMWRITE, memwr);
    reset = 1'b1; #1;
    chk_st("str.reset", S_FETCH, fetch_wait);
    chk("str.instret", 64'(instret), 64'd0);

    // Fetch timeout: FAULT after the 16th stalled cycle
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(); chk_st($sformatf("to.wait%0d", i), S_FETCH, fetch_wait);
    end
    step(); chk_st("to.fault", S_FAULT, flt_o);
    mif.mem_ready = 1'b1;
    step(); chk_st("to.sticky", S_FAULT, flt_o);
    chk("to.instret", 64'(instret), 64'd0);
    reset = 1'b1; #1;
    chk_st("to.reset", S_FETCH, fetch_go);
    reset = 1'b0; #1;

    // JALR and LUI
    opcode = OP_JALR;
    step(); chk_st("jalr.decode", S_DECODE, dec);
    step(); chk_st("jalr.jalr", S_JALR, ex(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0));
    step(); chk_st("jalr.wb", S_JALWB, ex(0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b00, 2'b10, 0));
    step(); chk("jalr.instret", 64'(instret), 64'd1);
    opcode = OP_LUI;
    step(); chk_st("lui.decode", S_DECODE, dec);
    step(); chk_st("lui.lui", S_LUI, ex(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0));
    step(); chk_st("lui.wb", S_ALUWB, aluwb);
    step(); chk_st("lui.done", S_FETCH, fetch_go);
    chk("lui.instret", 64'(instret), 64'd2);

    // Illegal opcode: FAULT after DECODE, frozen for 20 cycles
    opcode = 7'b0000000;
    step(); chk_st("ill.decode", S_DECODE, dec);
    step(); chk_st("ill.fault", S_FAULT, flt_o);
    for (int i = 0; i < 20; i++) begin
      mif.mem_ready = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      step(); chk_st($sformatf("ill.hold%0d", i), S_FAULT, flt_o);
    end
    chk("ill.instret", 64'(instret), 64'd2);
    mif.mem_ready = 1'b0;
    reset = 1'b1; #1;
    chk_st("ill.reset", S_FETCH, fetch_wait);
    chk("ill.reset_instret", 64'(instret), 64'd0);
    reset = 1'b0;
    step();

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences a multicycle RV32I datapath sharing one memory port between instruction fetch and load/store.
- Consumes the instruction register's opcode fields, the branch comparator outcome and the memory ready handshake.
- Drives per-state datapath enables and mux selects.
- Sits inside `top` beside the register file, ALU and memory.
- Also owns a memory watchdog and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: cycles a memory request may wait for mem_ready before the FSM enters FAULT.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- branch_taken  in  1  comparator result for the current B-type funct3, valid in EXECB.
- mem_ready  in  1  memory completed the request this cycle.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  write enable, qualified by mem_req.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- ir_write  out  1  load the instruction register and old-PC register.
- pc_write  out  1  load PC from the result bus.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- alu_ctrl  out  2  00 = add, 01 = subtract, 10 = decode from funct3/funct7.
- result_src  out  2  00 = ALU-out register, 01 = memory data, 10 = ALU result.
- fault  out  1  sticky: illegal opcode or memory timeout.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous):
  - state = FETCH, instret = 0, fault = 0, watchdog = 0.
  - All strobes 0 except mem_req = 1 and adr_src = 0; FETCH outputs are Moore.
- Outputs are a pure function of state, plus opcode in DECODE/EXEC states. No output depends combinationally on mem_ready, except that pc_write/ir_write in FETCH are gated by mem_ready.
- FETCH:
  - mem_req = 1, adr_src = 0; alu_src_a = 00, alu_src_b = 10, alu_ctrl = 00, result_src = 10.
  - On mem_ready: ir_write = 1, pc_write = 1 (PC += 4), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a = 01, alu_src_b = 01, add, so ALU-out holds oldPC + imm (branch/JAL target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> EXECB.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - 0010111 -> AUIPC.
  - Anything else -> FAULT.
- MEMADR: src_a = 10, src_b = 01, add. Next state is MEMREAD if opcode[5] = 0, else MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. On mem_ready go to MEMWB; else wait.
- MEMWB: reg_write = 1, result_src = 01. Retire, go to FETCH.
- MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1. On mem_ready retire and go to FETCH.
- EXECR: src_a = 10, src_b = 00, alu_ctrl = 10. Go to ALUWB.
- EXECI: src_a = 10, src_b = 01, alu_ctrl = 10. Go to ALUWB.
- LUI: src_a = 11, src_b = 01, add. Go to ALUWB.
- AUIPC: src_a = 01, src_b = 01, add. Go to ALUWB.
- ALUWB: reg_write = 1, result_src = 00. Retire, go to FETCH.
- EXECB: src_a = 10, src_b = 00, alu_ctrl = 01, result_src = 00. pc_write = branch_taken. Retire, go to FETCH.
- JAL: src_a = 01, src_b = 10, add, result_src = 00, pc_write = 1 (target from ALU-out). Go to JALWB.
- JALWB: reg_write = 1, result_src = 10 (oldPC + 4). Retire, go to FETCH.
  - Note: the rd value computes in JALWB via src_a = 01, src_b = 10.
- JALR: src_a = 10, src_b = 01, add, result_src = 10, pc_write = 1. Go to JALWB.
  - The register file is not written before the PC, so rd = rs1 is safe.
- Cycle counts with zero memory wait:
  - Load: 5.
  - R-type, I-type, LUI, AUIPC, store, JAL, JALR: 4.
  - Branch: 3.
- Watchdog:
  - Counts consecutive cycles in a memory state with mem_ready = 0.
  - Clears on mem_ready or on leaving the state.
  - When it reaches MEM_TIMEOUT, go to FAULT.
- FAULT: absorbing, fault = 1, all strobes 0, mem_req = 0. Only reset exits.
- instret:
  - Increments by 1 on each retire, wrapping modulo 2^CNT_W.
  - Frozen in FAULT.
- Reset mid-operation: reset during a pending mem_req abandons the request immediately; no write strobe survives reset.
- funct3 is used only to select the ALU operation externally; here it must be 000/010/100 etc. without check (no fault on funct3).

Decomposition:
- Package `riscv_ctrl_pkg` contains:
  - `state_t` enum.
  - Opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
  - Mux-select encodings for src_a, src_b, result_src and alu_ctrl.
- Sub-module `mem_watchdog`: counter, clear/enable inputs, timeout output, parameter MEM_TIMEOUT.

Test Plan:
- Release reset, mem_ready held 1, opcode 0110011 -> states FETCH, DECODE, EXECR, ALUWB; reg_write high only in cycle 4; instret = 1 after 4 cycles.
- Load (0000011), mem_ready low for 3 cycles in MEMREAD -> mem_req = 1, adr_src = 1 held for 4 cycles; MEMWB follows; total 8 cycles; instret +1.
- Branch (1100011) with branch_taken = 1, then again with branch_taken = 0 -> pc_write = 1 in EXECB only for the first case; 3 cycles each; no reg_write.
- JAL (1101111) -> pc_write in JAL state, then reg_write with result_src = 10 in JALWB; 4 cycles.
- Opcode 0000000 -> FAULT after DECODE; fault = 1; all strobes 0 for 20 cycles; instret frozen; reset clears fault and returns to FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT = 16 -> FAULT entered on cycle 16; asserting asynchronous reset mid-wait returns to FETCH with instret = 0 in the same cycle.
